// File: rtl/rv_wb_pkg.sv
// Shared types and sizes for the register-file writeback sequencer.
package rv_wb_pkg;

    localparam int REG_AW   = 5;
    localparam int REG_DW   = 32;
    localparam int WB_DEPTH = 4;

    typedef enum logic [1:0] {
        WB_IDLE = 2'b00,
        WB_BUSY = 2'b01,
        WB_FULL = 2'b10
    } wb_state_t;

endpackage

// File: rtl/wb_queue.sv
// DEPTH-entry circular buffer taking up to two pushes (A older than B) and one pop per cycle.
// Exposes the whole entry array and a valid mask so the top can search pending writes.
module wb_queue
    import rv_wb_pkg::*;
#(
    parameter  int DEPTH = WB_DEPTH,
    parameter  int AW    = REG_AW,
    parameter  int DW    = REG_DW,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_a_i,
    input  logic [AW-1:0]            addr_a_i,
    input  logic [DW-1:0]            data_a_i,
    input  logic                     push_b_i,
    input  logic [AW-1:0]            addr_b_i,
    input  logic [DW-1:0]            data_b_i,
    input  logic                     pop_i,
    output logic [CW-1:0]            count_o,
    output logic [CW-1:0]            count_next_o,
    output logic [AW-1:0]            head_addr_o,
    output logic [DW-1:0]            head_data_o,
    output logic [DEPTH-1:0][AW-1:0] entry_addr_o,
    output logic [DEPTH-1:0][DW-1:0] entry_data_o,
    output logic [DEPTH-1:0]         valid_o,
    output logic [PW-1:0]            rd_ptr_o
);

    logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][DW-1:0] data_q, data_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic [CW-1:0]            n_push;
    logic                     do_pop;

    // B is only meaningful alongside A, so the second slot is written only for a pair.
    assign do_pop = pop_i && (count_q != '0);
    assign n_push = CW'(push_a_i) + CW'(push_a_i && push_b_i);

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        if (push_a_i) begin
            addr_d[wr_ptr_q] = addr_a_i;
            data_d[wr_ptr_q] = data_a_i;
        end
        if (push_a_i && push_b_i) begin
            addr_d[wr_ptr_q + PW'(1)] = addr_b_i;
            data_d[wr_ptr_q + PW'(1)] = data_b_i;
        end
        wr_ptr_d = wr_ptr_q + PW'(n_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + n_push - CW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q   <= '0;
            data_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_o[i] = ({1'b0, PW'(i) - rd_ptr_q} < count_q);
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign head_addr_o  = addr_q[rd_ptr_q];
    assign head_data_o  = data_q[rd_ptr_q];
    assign entry_addr_o = addr_q;
    assign entry_data_o = data_q;
    assign rd_ptr_o     = rd_ptr_q;

endmodule

// File: rtl/reg_wb_sequencer.sv
// Writeback sequencer: arbitrates ALU/load results into an in-order queue and retires one per cycle.
// Define REG_WB_BYPASS_EN to report queued-but-unwritten values on the RQ query ports.
module reg_wb_sequencer
    import rv_wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          alu_valid_i,
    output logic          alu_ready_o,
    input  logic [AW-1:0] alu_addr_i,
    input  logic [DW-1:0] alu_data_i,
    input  logic          ld_valid_i,
    output logic          ld_ready_o,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [DW-1:0] ld_data_i,
    output logic [DW-1:0] wb_data_o,
    output logic [AW-1:0] wb_addr_o,
    output logic          wb_write_o,
    input  logic [AW-1:0] rq_addr1_i,
    input  logic [AW-1:0] rq_addr2_i,
    output logic          rq_hit1_o,
    output logic          rq_hit2_o,
    output logic [DW-1:0] rq_data1_o,
    output logic [DW-1:0] rq_data2_o,
    output logic [1:0]    state_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0]            count;
    logic [CW-1:0]            count_next;
    logic [CW-1:0]            free;
    logic                     alu_accept;
    logic                     ld_accept;
    logic                     alu_push;
    logic                     ld_push;
    logic                     push_a;
    logic                     push_b;
    logic [AW-1:0]            addr_a;
    logic [DW-1:0]            data_a;
    logic [AW-1:0]            head_addr;
    logic [DW-1:0]            head_data;
    logic [DEPTH-1:0][AW-1:0] entry_addr;
    logic [DEPTH-1:0][DW-1:0] entry_data;
    logic [DEPTH-1:0]         valid;
    logic [PW-1:0]            rd_ptr;
    wb_state_t                state_q;

    // Readiness uses the registered free count only; a same-edge pop earns no credit.
    assign free        = CW'(DEPTH) - count;
    assign alu_ready_o = (free != '0);
    assign ld_ready_o  = (free >= CW'(2)) || ((free == CW'(1)) && !alu_valid_i);
    assign alu_accept  = alu_valid_i && alu_ready_o;
    assign ld_accept   = ld_valid_i && ld_ready_o;

    // Writes to x0 complete the handshake but are dropped; the load is older when both push.
    assign alu_push = alu_accept && (alu_addr_i != '0);
    assign ld_push  = ld_accept && (ld_addr_i != '0);
    assign push_a   = ld_push || alu_push;
    assign addr_a   = ld_push ? ld_addr_i : alu_addr_i;
    assign data_a   = ld_push ? ld_data_i : alu_data_i;
    assign push_b   = ld_push && alu_push;

    wb_queue #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_queue (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .push_a_i     (push_a),
        .addr_a_i     (addr_a),
        .data_a_i     (data_a),
        .push_b_i     (push_b),
        .addr_b_i     (alu_addr_i),
        .data_b_i     (alu_data_i),
        .pop_i        (wb_write_o),
        .count_o      (count),
        .count_next_o (count_next),
        .head_addr_o  (head_addr),
        .head_data_o  (head_data),
        .entry_addr_o (entry_addr),
        .entry_data_o (entry_data),
        .valid_o      (valid),
        .rd_ptr_o     (rd_ptr)
    );

    assign wb_write_o = (count != '0);
    assign wb_addr_o  = wb_write_o ? head_addr : '0;
    assign wb_data_o  = wb_write_o ? head_data : '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= WB_IDLE;
        end else if (count_next == '0) begin
            state_q <= WB_IDLE;
        end else if (count_next == CW'(DEPTH)) begin
            state_q <= WB_FULL;
        end else begin
            state_q <= WB_BUSY;
        end
    end

    assign state_o = state_q;

`ifdef REG_WB_BYPASS_EN
    logic          hit1, hit2;
    logic [DW-1:0] data1, data2;

    // Walk from oldest to youngest so the last match is the value the register will end up with.
    always_comb begin
        logic [PW-1:0] idx;
        idx   = '0;
        hit1  = 1'b0;
        hit2  = 1'b0;
        data1 = '0;
        data2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (valid[idx]) begin
                if ((rq_addr1_i != '0) && (entry_addr[idx] == rq_addr1_i)) begin
                    hit1  = 1'b1;
                    data1 = entry_data[idx];
                end
                if ((rq_addr2_i != '0) && (entry_addr[idx] == rq_addr2_i)) begin
                    hit2  = 1'b1;
                    data2 = entry_data[idx];
                end
            end
        end
    end

    assign rq_hit1_o  = hit1;
    assign rq_hit2_o  = hit2;
    assign rq_data1_o = data1;
    assign rq_data2_o = data2;
`else
    logic unused_bypass;

    assign rq_hit1_o     = 1'b0;
    assign rq_hit2_o     = 1'b0;
    assign rq_data1_o    = '0;
    assign rq_data2_o    = '0;
    assign unused_bypass = ^{entry_addr, entry_data, valid, rd_ptr, rq_addr1_i, rq_addr2_i};
`endif

endmodule

// File: tb/tb_reg_wb_sequencer.sv
// Directed bench for reg_wb_sequencer: a DEPTH=4 instance for ordering/arbitration/bypass
// and a DEPTH=2 instance, the only size where two pushes into an empty queue make it FULL.
module tb_reg_wb_sequencer;

    localparam int AW = 5;
    localparam int DW = 32;
`ifdef REG_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          aluValid, aluReady, ldValid, ldReady;
    logic [AW-1:0] aluAddr, ldAddr, wbAddr, rqAddr1, rqAddr2;
    logic [DW-1:0] aluData, ldData, wbData, rqData1, rqData2;
    logic          wbWrite, rqHit1, rqHit2;
    logic [1:0]    state;

    logic          sAluValid, sAluReady, sLdValid, sLdReady;
    logic [AW-1:0] sAluAddr, sLdAddr, sWbAddr;
    logic [DW-1:0] sAluData, sLdData, sWbData, sRqData1, sRqData2;
    logic          sWbWrite, sRqHit1, sRqHit2;
    logic [1:0]    sState;

    int            testsRun    = 0;
    int            testsFailed = 0;
    logic [DW-1:0] rf [32];
    logic [AW-1:0] logAddr [$];
    logic [DW-1:0] logData [$];

    reg_wb_sequencer #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
        .clk_i(clk), .reset_i(reset),
        .alu_valid_i(aluValid), .alu_ready_o(aluReady), .alu_addr_i(aluAddr), .alu_data_i(aluData),
        .ld_valid_i(ldValid), .ld_ready_o(ldReady), .ld_addr_i(ldAddr), .ld_data_i(ldData),
        .wb_data_o(wbData), .wb_addr_o(wbAddr), .wb_write_o(wbWrite),
        .rq_addr1_i(rqAddr1), .rq_addr2_i(rqAddr2),
        .rq_hit1_o(rqHit1), .rq_hit2_o(rqHit2), .rq_data1_o(rqData1), .rq_data2_o(rqData2),
        .state_o(state)
    );

    reg_wb_sequencer #(.DEPTH(2), .AW(AW), .DW(DW)) dutSmall (
        .clk_i(clk), .reset_i(reset),
        .alu_valid_i(sAluValid), .alu_ready_o(sAluReady), .alu_addr_i(sAluAddr), .alu_data_i(sAluData),
        .ld_valid_i(sLdValid), .ld_ready_o(sLdReady), .ld_addr_i(sLdAddr), .ld_data_i(sLdData),
        .wb_data_o(sWbData), .wb_addr_o(sWbAddr), .wb_write_o(sWbWrite),
        .rq_addr1_i(rqAddr1), .rq_addr2_i(rqAddr2),
        .rq_hit1_o(sRqHit1), .rq_hit2_o(sRqHit2), .rq_data1_o(sRqData1), .rq_data2_o(sRqData2),
        .state_o(sState)
    );

    always #5 clk = ~clk;

    // Register-file model plus a log of every retired write, in order.
    always @(posedge clk) begin
        if (!reset && wbWrite) begin
            rf[wbAddr] <= wbData;
            logAddr.push_back(wbAddr);
            logData.push_back(wbData);
        end
    end

    // A handshake while FULL would overflow the queue.
    always @(posedge clk) begin
        if (!reset && sState == 2'b10 && ((sAluValid && sAluReady) || (sLdValid && sLdReady))) begin
            testsFailed++;
            $display("[TB] FAIL protocol_overflow accepted while FULL");
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        aluValid = 1'b0; aluAddr = '0; aluData = '0;
        ldValid = 1'b0; ldAddr = '0; ldData = '0;
        sAluValid = 1'b0; sAluAddr = '0; sAluData = '0;
        sLdValid = 1'b0; sLdAddr = '0; sLdData = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; rqAddr1 = '0; rqAddr2 = '0;
        idleInputs();
        repeat (3) step();
        testsRun++; if (state !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_state got %b want 00", state); end
        testsRun++; if (wbWrite !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_wbwrite got %b want 0", wbWrite); end
        testsRun++; if (wbAddr !== 5'd0 || wbData !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_wbbus got %h/%h want 0/0", wbAddr, wbData); end
        testsRun++; if (rqHit1 !== 1'b0 || rqHit2 !== 1'b0 || rqData1 !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_rq got %b%b/%h want 00/0", rqHit1, rqHit2, rqData1); end
        testsRun++; if (sState !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_small_state got %b want 00", sState); end
        reset = 1'b0;
        #1;
        testsRun++; if (aluReady !== 1'b1 || ldReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ready got %b%b want 11", aluReady, ldReady); end
    endtask

    task automatic test_single_write();
        aluValid = 1'b1; aluAddr = 5'd5; aluData = 32'hDEADBEEF;
        #1;
        testsRun++; if (aluReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_ready got %b want 1", aluReady); end
        step();
        idleInputs();
        testsRun++; if (wbWrite !== 1'b1 || wbAddr !== 5'd5 || wbData !== 32'hDEADBEEF) begin testsFailed++; $display("[TB] FAIL single_wb got %b/%0d/%h want 1/5/deadbeef", wbWrite, wbAddr, wbData); end
        testsRun++; if (state !== 2'b01) begin testsFailed++; $display("[TB] FAIL single_state got %b want 01", state); end
        step();
        testsRun++; if (rf[5] !== 32'hDEADBEEF) begin testsFailed++; $display("[TB] FAIL single_rf got %h want deadbeef", rf[5]); end
        testsRun++; if (wbWrite !== 1'b0 || state !== 2'b00) begin testsFailed++; $display("[TB] FAIL single_idle got %b/%b want 0/00", wbWrite, state); end
    endtask

    task automatic test_dual_order();
        logAddr.delete(); logData.delete();
        ldValid = 1'b1; ldAddr = 5'd3; ldData = 32'h11;
        aluValid = 1'b1; aluAddr = 5'd4; aluData = 32'h22;
        step();
        idleInputs();
        testsRun++; if (state !== 2'b01 || wbAddr !== 5'd3 || wbData !== 32'h11) begin testsFailed++; $display("[TB] FAIL dual_first got %b/%0d/%h want 01/3/11", state, wbAddr, wbData); end
        step();
        testsRun++; if (state !== 2'b01 || wbAddr !== 5'd4 || wbData !== 32'h22) begin testsFailed++; $display("[TB] FAIL dual_second got %b/%0d/%h want 01/4/22", state, wbAddr, wbData); end
        step();
        testsRun++; if (state !== 2'b00 || logAddr.size() != 2) begin testsFailed++; $display("[TB] FAIL dual_drain got %b/%0d writes want 00/2", state, logAddr.size()); end
        testsRun++; if (rf[3] !== 32'h11 || rf[4] !== 32'h22) begin testsFailed++; $display("[TB] FAIL dual_rf got %h/%h want 11/22", rf[3], rf[4]); end
    endtask

    task automatic test_fill_full();
        sLdValid = 1'b1; sLdAddr = 5'd6; sLdData = 32'h66;
        sAluValid = 1'b1; sAluAddr = 5'd7; sAluData = 32'h77;
        step();
        sLdAddr = 5'd8; sAluAddr = 5'd9;
        #1;
        testsRun++; if (sState !== 2'b10) begin testsFailed++; $display("[TB] FAIL full_state got %b want 10", sState); end
        testsRun++; if (sAluReady !== 1'b0 || sLdReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_ready got %b%b want 00", sAluReady, sLdReady); end
        testsRun++; if (sWbWrite !== 1'b1 || sWbAddr !== 5'd6) begin testsFailed++; $display("[TB] FAIL full_head got %b/%0d want 1/6", sWbWrite, sWbAddr); end
        idleInputs();
        step();
        testsRun++; if (sState !== 2'b01 || sWbAddr !== 5'd7 || sWbData !== 32'h77) begin testsFailed++; $display("[TB] FAIL full_pop got %b/%0d/%h want 01/7/77", sState, sWbAddr, sWbData); end
        step();
        testsRun++; if (sState !== 2'b00 || sWbWrite !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_drain got %b/%b want 00/0", sState, sWbWrite); end
    endtask

    task automatic test_free_one();
        logic [AW-1:0] expAddr [6];
        logic [DW-1:0] expData [6];
        expAddr = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd15, 5'd14};
        expData = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h105, 32'h104};
        logAddr.delete(); logData.delete();
        ldValid = 1'b1; ldAddr = 5'd10; ldData = 32'h100;
        aluValid = 1'b1; aluAddr = 5'd11; aluData = 32'h101;
        step();
        ldAddr = 5'd12; ldData = 32'h102; aluAddr = 5'd13; aluData = 32'h103;
        #1;
        testsRun++; if (aluReady !== 1'b1 || ldReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL free2_ready got %b%b want 11", aluReady, ldReady); end
        step();
        ldAddr = 5'd14; ldData = 32'h104; aluAddr = 5'd15; aluData = 32'h105;
        #1;
        testsRun++; if (aluReady !== 1'b1 || ldReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL free1_ready got %b%b want 10", aluReady, ldReady); end
        testsRun++; if (state !== 2'b01) begin testsFailed++; $display("[TB] FAIL free1_state got %b want 01", state); end
        step();
        aluValid = 1'b0;
        #1;
        testsRun++; if (ldReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL free1_ld_next got %b want 1", ldReady); end
        step();
        idleInputs();
        repeat (3) step();
        testsRun++; if (state !== 2'b00 || logAddr.size() != 6) begin testsFailed++; $display("[TB] FAIL free1_drain got %b/%0d writes want 00/6", state, logAddr.size()); end
        for (int i = 0; i < 6 && i < logAddr.size(); i++) begin
            testsRun++;
            if (logAddr[i] !== expAddr[i] || logData[i] !== expData[i]) begin
                testsFailed++;
                $display("[TB] FAIL free1_order[%0d] got %0d/%h want %0d/%h", i, logAddr[i], logData[i], expAddr[i], expData[i]);
            end
        end
    endtask

    task automatic test_x0();
        logAddr.delete(); logData.delete();
        aluValid = 1'b1; aluAddr = 5'd0; aluData = 32'hFF;
        #1;
        testsRun++; if (aluReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL x0_ready got %b want 1", aluReady); end
        step();
        idleInputs();
        testsRun++; if (state !== 2'b00 || wbWrite !== 1'b0) begin testsFailed++; $display("[TB] FAIL x0_dropped got %b/%b want 00/0", state, wbWrite); end
        ldValid = 1'b1; ldAddr = 5'd0; ldData = 32'h55;
        aluValid = 1'b1; aluAddr = 5'd9; aluData = 32'h99;
        step();
        idleInputs();
        testsRun++; if (state !== 2'b01 || wbAddr !== 5'd9 || wbData !== 32'h99) begin testsFailed++; $display("[TB] FAIL x0_pair got %b/%0d/%h want 01/9/99", state, wbAddr, wbData); end
        step();
        testsRun++; if (state !== 2'b00 || logAddr.size() != 1) begin testsFailed++; $display("[TB] FAIL x0_count got %b/%0d writes want 00/1", state, logAddr.size()); end
        testsRun++; if (rf[0] !== 32'd0) begin testsFailed++; $display("[TB] FAIL x0_rf got %h want 0", rf[0]); end
    endtask

    task automatic test_bypass_reset();
        ldValid = 1'b1; ldAddr = 5'd7; ldData = 32'h1;
        aluValid = 1'b1; aluAddr = 5'd7; aluData = 32'h2;
        rqAddr1 = 5'd7; rqAddr2 = 5'd3;
        step();
        idleInputs();
        testsRun++; if (rqHit1 !== BYPASS || rqData1 !== (BYPASS ? 32'h2 : 32'h0)) begin testsFailed++; $display("[TB] FAIL bypass_youngest got %b/%h want %b/%h", rqHit1, rqData1, BYPASS, BYPASS ? 32'h2 : 32'h0); end
        testsRun++; if (rqHit2 !== 1'b0 || rqData2 !== 32'h0) begin testsFailed++; $display("[TB] FAIL bypass_miss got %b/%h want 0/0", rqHit2, rqData2); end
        rqAddr2 = 5'd7;
        step();
        testsRun++; if (rqHit2 !== BYPASS || rqData2 !== (BYPASS ? 32'h2 : 32'h0)) begin testsFailed++; $display("[TB] FAIL bypass_head got %b/%h want %b/%h", rqHit2, rqData2, BYPASS, BYPASS ? 32'h2 : 32'h0); end
        step();
        testsRun++; if (rqHit1 !== 1'b0 || state !== 2'b00) begin testsFailed++; $display("[TB] FAIL bypass_empty got %b/%b want 0/00", rqHit1, state); end
        ldValid = 1'b1; ldAddr = 5'd20; ldData = 32'h200;
        aluValid = 1'b1; aluAddr = 5'd21; aluData = 32'h201;
        step();
        ldAddr = 5'd22; ldData = 32'h202; aluAddr = 5'd23; aluData = 32'h203;
        step();
        idleInputs();
        rqAddr1 = 5'd22; rqAddr2 = 5'd0;
        #1;
        testsRun++; if (rqHit1 !== BYPASS || rqData1 !== (BYPASS ? 32'h202 : 32'h0) || state !== 2'b01) begin testsFailed++; $display("[TB] FAIL bypass_three got %b/%h/%b want %b/%h/01", rqHit1, rqData1, state, BYPASS, BYPASS ? 32'h202 : 32'h0); end
        reset = 1'b1;
        aluValid = 1'b1; aluAddr = 5'd24; aluData = 32'h240;
        step();
        reset = 1'b0;
        idleInputs();
        #1;
        testsRun++; if (state !== 2'b00 || wbWrite !== 1'b0 || rqHit1 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_flush got %b/%b/%b want 00/0/0", state, wbWrite, rqHit1); end
        step();
        testsRun++; if (wbWrite !== 1'b0 || state !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_push_lost got %b/%b want 0/00", wbWrite, state); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        test_reset();
        test_single_write();
        test_dual_order();
        test_fill_full();
        test_free_one();
        test_x0();
        test_bypass_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
